// File: rtl/systolic_result_writer.sv
// Write-back engine for the systolic array result matrix: snapshots Out on start
// and streams the valid corner to memory row by row in masked BW-word beats.
module systolic_result_writer #(
  parameter int N          = 8,
  parameter int BW         = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 6
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [N*N*DATA_WIDTH-1:0]    out_i,
  input  logic [ADDR_WIDTH-1:0]        base_c_i,
  input  logic [DIM_WIDTH-1:0]         dim_col_c_i,
  input  logic [3:0]                   n_rows_i,
  input  logic [3:0]                   n_cols_i,
  input  logic                         write_ready_i,
  output logic                         write_o,
  output logic [ADDR_WIDTH-1:0]        write_addr_o,
  output logic [BW*DATA_WIDTH-1:0]     writedata_o,
  output logic [BW-1:0]                write_mask_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int NG = N / BW;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_e;

  state_e                     state_q, state_d;
  logic [RW-1:0]              r_q, r_d;
  logic [GW-1:0]              g_q, g_d;

  logic [N*N*DATA_WIDTH-1:0]  snap_q;
  logic [ADDR_WIDTH-1:0]      base_q;
  logic [DIM_WIDTH-1:0]       stride_q;
  logic [3:0]                 nrows_q, ncols_q;
  logic [3:0]                 nrows_cl, ncols_cl;

  logic                       write_q, write_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [BW*DATA_WIDTH-1:0]   data_q, data_d;
  logic [BW-1:0]              mask_q, mask_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [N*N*DATA_WIDTH-1:0]  src_mat;
  logic [ADDR_WIDTH-1:0]      src_base;
  logic [DIM_WIDTH-1:0]       src_stride;
  logic [3:0]                 src_ncols;
  logic                       last_g, last_r;

  assign nrows_cl = (n_rows_i > 4'(N)) ? 4'(N) : n_rows_i;
  assign ncols_cl = (n_cols_i > 4'(N)) ? 4'(N) : n_cols_i;

  assign last_g = ((int'(g_q) + 1) * BW) >= int'(ncols_q);
  assign last_r = int'(r_q) == (int'(nrows_q) - 1);

  // State register plus the registered outputs and the operation snapshot.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      r_q      <= '0;
      g_q      <= '0;
      snap_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      nrows_q  <= '0;
      ncols_q  <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      g_q     <= g_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (state_q == IDLE && start_i) begin
        snap_q   <= out_i;
        base_q   <= base_c_i;
        stride_q <= dim_col_c_i;
        nrows_q  <= nrows_cl;
        ncols_q  <= ncols_cl;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          r_d     = '0;
          g_d     = '0;
          state_d = (nrows_cl == 4'd0 || ncols_cl == 4'd0) ? FINISH : WRITE;
        end
      end
      WRITE: begin
        if (write_ready_i) begin
          if (!last_g) begin
            g_d = g_q + GW'(1);
          end else begin
            g_d = '0;
            if (last_r) state_d = FINISH;
            else        r_d     = r_q + RW'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next-cycle beat is built from the live inputs on the start edge, since the
  // snapshot registers only load on that same edge.
  always_comb begin
    src_mat    = (state_q == IDLE) ? out_i       : snap_q;
    src_base   = (state_q == IDLE) ? base_c_i    : base_q;
    src_stride = (state_q == IDLE) ? dim_col_c_i : stride_q;
    src_ncols  = (state_q == IDLE) ? ncols_cl    : ncols_q;
    write_d    = (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
    addr_d     = '0;
    data_d     = '0;
    mask_d     = '0;
    if (write_d) begin
      addr_d = src_base + ADDR_WIDTH'(r_d) * ADDR_WIDTH'(src_stride)
                        + ADDR_WIDTH'(g_d) * ADDR_WIDTH'(BW);
      for (int k = 0; k < BW; k++) begin
        data_d[k*DATA_WIDTH +: DATA_WIDTH] =
          src_mat[(int'(r_d)*N + int'(g_d)*BW + k)*DATA_WIDTH +: DATA_WIDTH];
        mask_d[k] = (int'(g_d)*BW + k) < int'(src_ncols);
      end
    end
  end

  assign write_o      = write_q;
  assign write_addr_o = addr_q;
  assign writedata_o  = data_q;
  assign write_mask_o = mask_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_systolic_result_writer.sv
// Bench for systolic_result_writer: queue-of-beats model checked every cycle,
// plus directed scenarios with hand-computed addresses, masks and latencies.
module tb_systolic_result_writer;
  localparam int N = 8, BW = 4, DW = 32, AW = 12, DMW = 6;
  localparam int NG = N / BW;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [N*N*DW-1:0]    out_v = '0;
  logic [AW-1:0]        base = '0;
  logic [DMW-1:0]       stride = '0;
  logic [3:0]           nr = '0, nc = '0;
  logic                 ready = 1'b1;
  logic                 wr;
  logic [AW-1:0]        waddr;
  logic [BW*DW-1:0]     wdata;
  logic [BW-1:0]        wmask;
  logic                 busy, done;

  always #5 clock = ~clock;

  systolic_result_writer #(.N(N), .BW(BW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .out_i(out_v),
    .base_c_i(base), .dim_col_c_i(stride), .n_rows_i(nr), .n_cols_i(nc),
    .write_ready_i(ready), .write_o(wr), .write_addr_o(waddr), .writedata_o(wdata),
    .write_mask_o(wmask), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic [AW-1:0]    a;
    logic [BW*DW-1:0] d;
    logic [BW-1:0]    m;
  } beat_t;

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mat [N][N];
  beat_t q[$];
  int ph = 0;          // 0 idle, 1 writing, 2 done cycle
  int t = 0;           // cycles since accepted start
  int done_t = -1, retires = 0, dones = 0;
  logic [AW-1:0]    ret_addr[$];
  logic [BW-1:0]    ret_mask[$];
  logic [BW*DW-1:0] ret_data[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic set_mat(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat[r][c] = (mode == 0) ? DW'(r*8 + c) : DW'(32'hA000_0000 + r*16 + c);
        out_v[(r*N + c)*DW +: DW] = mat[r][c];
      end
  endtask

  task automatic build_job();
    int nrc, ncc, a;
    beat_t b;
    nrc = (int'(nr) > N) ? N : int'(nr);
    ncc = (int'(nc) > N) ? N : int'(nc);
    q.delete();
    if (nrc == 0 || ncc == 0) return;
    for (int r = 0; r < nrc; r++)
      for (int g = 0; g < NG; g++)
        if (g*BW < ncc) begin
          a = (int'(base) + r*int'(stride) + g*BW) % (1 << AW);
          b.a = AW'(a);
          for (int k = 0; k < BW; k++) begin
            b.d[k*DW +: DW] = mat[r][g*BW + k];
            b.m[k] = (g*BW + k) < ncc;
          end
          q.push_back(b);
        end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      ph = 0;
      q.delete();
      chk("rst_write", wr, 0);
      chk("rst_addr", waddr, 0);
      chk("rst_data", wdata, 0);
      chk("rst_mask", wmask, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end else begin
      t++;
      chk("write", wr, ph == 1);
      chk("busy", busy, ph != 0);
      chk("done", done, ph == 2);
      if (ph == 1 && q.size() > 0) begin
        chk("addr", waddr, q[0].a);
        chk("data", wdata, q[0].d);
        chk("mask", wmask, q[0].m);
      end else begin
        chk("addr_idle", waddr, 0);
        chk("data_idle", wdata, 0);
        chk("mask_idle", wmask, 0);
      end
      if (done) begin dones++; done_t = t; end
      if (wr && ready) begin
        retires++;
        ret_addr.push_back(waddr);
        ret_mask.push_back(wmask);
        ret_data.push_back(wdata);
      end
      case (ph)
        0: if (start) begin
             build_job();
             ph = (q.size() == 0) ? 2 : 1;
             t = 0;
           end
        1: if (ready) begin
             if (q.size() > 0) void'(q.pop_front());
             if (q.size() == 0) ph = 2;
           end
        default: ph = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    retires = 0; dones = 0; done_t = -1;
    ret_addr.delete(); ret_mask.delete(); ret_data.delete();
  endtask

  task automatic setup(input int b, input int s, input int r, input int c);
    base = AW'(b); stride = DMW'(s); nr = 4'(r); nc = 4'(c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((ph != 0 || busy) && i < 300) begin step(); i++; end
    chk("idle_timeout", i >= 300, 0);
  endtask

  task automatic wait_t(input int target);
    int i = 0;
    while (t != target && i < 300) begin step(); i++; end
    chk("wait_timeout", i >= 300, 0);
  endtask

  initial begin
    set_mat(0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    step();

    // Full 8x8, always ready
    clear_logs(); setup(12'h100, 8, 8, 8); pulse_start(); wait_idle();
    chk("t1_retires", retires, 16);
    chk("t1_done_t", done_t, 17);
    chk("t1_dones", dones, 1);
    if (retires == 16) begin
      chk("t1_addr0", ret_addr[0], 12'h100);
      chk("t1_addr1", ret_addr[1], 12'h104);
      chk("t1_addr15", ret_addr[15], 12'h13C);
      chk("t1_mask15", ret_mask[15], 4'hF);
      chk("t1_data0", ret_data[0], {32'd3, 32'd2, 32'd1, 32'd0});
    end

    // 3x6 corner, stride 10; Out changed after start must not matter
    clear_logs(); setup(12'h200, 10, 3, 6); pulse_start(); set_mat(1); wait_idle();
    chk("t2_retires", retires, 6);
    chk("t2_done_t", done_t, 7);
    if (retires == 6) begin
      chk("t2_addr1", ret_addr[1], 12'h204);
      chk("t2_addr2", ret_addr[2], 12'h20A);
      chk("t2_addr3", ret_addr[3], 12'h20E);
      chk("t2_addr4", ret_addr[4], 12'h214);
      chk("t2_addr5", ret_addr[5], 12'h218);
      chk("t2_mask1", ret_mask[1], 4'b0011);
      chk("t2_mask2", ret_mask[2], 4'hF);
      chk("t2_data3", ret_data[3], {32'd15, 32'd14, 32'd13, 32'd12});
    end
    set_mat(0);

    // 2x4 with write_ready pattern 1,0,0,1
    clear_logs(); setup(12'h300, 8, 2, 4); pulse_start();
    ready = 1'b1; step();
    ready = 1'b0; step();
    ready = 1'b0; step();
    ready = 1'b1; wait_idle();
    chk("t3_retires", retires, 2);
    chk("t3_done_t", done_t, 5);
    if (retires == 2) chk("t3_addr1", ret_addr[1], 12'h308);

    // Address wrap; n_cols=15 clamps to 8
    clear_logs(); setup(12'hFF8, 8, 2, 15); pulse_start(); wait_idle();
    chk("t4_retires", retires, 4);
    if (retires == 4) begin
      chk("t4_addr1", ret_addr[1], 12'hFFC);
      chk("t4_addr2", ret_addr[2], 12'h000);
      chk("t4_addr3", ret_addr[3], 12'h004);
    end

    // Zero rows
    clear_logs(); setup(12'h100, 8, 0, 8); pulse_start(); wait_idle();
    chk("t5a_retires", retires, 0);
    chk("t5a_done_t", done_t, 1);

    // Start mid-operation and in the done cycle are both ignored
    clear_logs(); setup(12'h040, 8, 8, 8); pulse_start();
    step(); step(); pulse_start();
    wait_t(16); pulse_start();
    repeat (4) step();
    chk("t5b_retires", retires, 16);
    chk("t5b_dones", dones, 1);
    chk("t5b_busy", busy, 0);

    // Reset during beat 5, then a clean restart
    clear_logs(); setup(12'h500, 8, 8, 8); pulse_start();
    wait_t(4);
    chk("t6_pre_write", wr, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_write", wr, 0);
    chk("t6_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("t6_no_done", dones, 0);
    chk("t6_partial", retires, 4);
    clear_logs(); pulse_start(); wait_idle();
    chk("t6_retires", retires, 16);
    chk("t6_done_t", done_t, 17);
    if (retires == 16) chk("t6_addr0", ret_addr[0], 12'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
